// File: rtl/data_memory_responder_if.sv
// Request/response bus between the execute/memory stage and the data-memory responder.
// The master drives requests and accepts responses; the slave is the memory side.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Single-outstanding load/store responder over a little-endian word array, with
// byte/half-word lane handling, alignment/range checking and load extension.
module data_memory_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  data_memory_responder_if.slave       io_bus
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);
  localparam logic [29:0] BASE_W   = ADDR_BASE[31:2];
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [29:0]      w_word_off;
  logic [IDX_W-1:0] w_index;
  logic             w_out_of_range;
  logic             w_illegal;
  logic             w_misaligned;
  logic             w_error;
  logic             w_commit;
  logic [3:0]       w_be;
  logic [31:0]      w_wlane;
  logic [31:0]      w_rword;
  logic [7:0]       w_lane [4];
  logic [7:0]       w_rbyte;
  logic [15:0]      w_rhalf;
  logic [31:0]      w_load_data;

  // Base is word aligned, so range arithmetic is done on word addresses only.
  assign w_word_off     = r_addr[31:2] - BASE_W;
  assign w_index        = w_word_off[IDX_W-1:0];
  assign w_out_of_range = (r_addr[31:2] < BASE_W) || (w_word_off >= DEPTH_L);
  assign w_illegal      = (r_size == 2'd2);
  assign w_misaligned   = ((r_size == 2'd1) && r_addr[0]) ||
                          ((r_size == 2'd3) && (r_addr[1:0] != 2'b00));
  assign w_error        = w_illegal || w_misaligned || w_out_of_range;
  assign w_commit       = (r_state == S_ACCESS) && (r_cnt == 4'd0) && r_write && !w_error;

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = r_wdata;
    case (r_size)
      2'd0: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      2'd3:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_rword = r_mem[w_index];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = w_rword[8*gi +: 8];
    end
  endgenerate

  assign w_rbyte = w_lane[r_addr[1:0]];
  assign w_rhalf = r_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load_data = w_rword;
    case (r_size)
      2'd0:    w_load_data = r_unsigned ? {24'h0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
      2'd1:    w_load_data = r_unsigned ? {16'h0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
      default: w_load_data = w_rword;
    endcase
  end

  // Array is deliberately left out of reset; commit is gated by the reset FSM state.
  always_ff @(posedge i_clock) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_index][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (io_bus.req_valid && r_req_ready) begin
            r_write     <= io_bus.req_write;
            r_addr      <= io_bus.req_addr;
            r_wdata     <= io_bus.req_wdata;
            r_size      <= io_bus.req_size;
            r_unsigned  <= io_bus.req_unsigned;
            r_cnt       <= CNT_INIT;
            r_req_ready <= 1'b0;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_resp_valid <= 1'b1;
            r_resp_error <= w_error;
            r_resp_rdata <= (w_error || r_write) ? 32'h0 : w_load_data;
            r_state      <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESPOND: begin
          if (io_bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready  = r_req_ready;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_rdata = r_resp_rdata;
  assign io_bus.resp_error = r_resp_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: stores/loads, lane extension, errors,
// back-pressure and reset during ACCESS/RESPOND, with hand-computed expectations.
module tb_data_memory_responder;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  data_memory_responder_if bus ();

  data_memory_responder #(
    .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .io_bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic u, input logic keep);
    logic rdy;
    logic acc;
    acc = 1'b0;
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_size     = s;
    bus.req_unsigned = u;
    bus.req_valid    = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      rdy = bus.req_ready;
      @(posedge clk); #1;
      if (rdy) acc = 1'b1;
    end
    chk1("accept", acc, 1'b1);
    chk1("ready_drop", bus.req_ready, 1'b0);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic hs();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic u,
                     output logic [31:0] rd, output logic er);
    int lat;
    start_req(w, a, d, s, u, 1'b0);
    wait_resp(lat);
    chk("latency", 32'(lat), 32'(LAT));
    rd = bus.resp_rdata;
    er = bus.resp_error;
    hs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] e_addr [7];
    logic [1:0]  e_size [7];
    logic        e_wr   [7];

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.resp_ready = 1'b0;

    // Reset values, then ready rises one edge after release.
    repeat (3) @(posedge clk); #1;
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk1("rst_error", bus.resp_error, 1'b0);
    #2 rst_n = 1'b1;
    #1 chk1("ready_before_edge", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("ready_after_edge", bus.req_ready, 1'b1);

    // Word store / load.
    txn(1'b1, BASE + 0, 32'hCAFEF00D, 2'd3, 1'b0, rd, er);
    txn(1'b1, BASE + 4, 32'hDEADBEEF, 2'd3, 1'b0, rd, er);
    chk("st_word_rdata", rd, 32'h0); chk1("st_word_err", er, 1'b0);
    txn(1'b0, BASE + 4, 32'h0, 2'd3, 1'b0, rd, er);
    chk("ld_word", rd, 32'hDEADBEEF); chk1("ld_word_err", er, 1'b0);

    // Byte lanes.
    txn(1'b1, BASE + 8, 32'h0, 2'd3, 1'b0, rd, er);
    txn(1'b1, BASE + 10, 32'h123456A5, 2'd0, 1'b0, rd, er);
    txn(1'b0, BASE + 8, 32'h0, 2'd3, 1'b0, rd, er);
    chk("byte_word", rd, 32'h00A50000);
    txn(1'b0, BASE + 10, 32'h0, 2'd0, 1'b0, rd, er);
    chk("byte_signed", rd, 32'hFFFFFFA5);
    txn(1'b0, BASE + 10, 32'h0, 2'd0, 1'b1, rd, er);
    chk("byte_unsigned", rd, 32'h000000A5);

    // Half-word lanes.
    txn(1'b1, BASE + 12, 32'h11223344, 2'd3, 1'b0, rd, er);
    txn(1'b1, BASE + 14, 32'hFFFF8001, 2'd1, 1'b0, rd, er);
    txn(1'b0, BASE + 12, 32'h0, 2'd3, 1'b0, rd, er);
    chk("half_word", rd, 32'h80013344);
    txn(1'b0, BASE + 14, 32'h0, 2'd1, 1'b0, rd, er);
    chk("half_signed", rd, 32'hFFFF8001);
    txn(1'b0, BASE + 14, 32'h0, 2'd1, 1'b1, rd, er);
    chk("half_unsigned", rd, 32'h00008001);
    txn(1'b0, BASE + 12, 32'h0, 2'd1, 1'b0, rd, er);
    chk("half_low_signed", rd, 32'h00003344);
    txn(1'b0, BASE + 13, 32'h0, 2'd0, 1'b0, rd, er);
    chk("byte_lane1", rd, 32'h00000033);

    // Error cases: none may return data or modify the array.
    e_addr[0] = BASE + 5;          e_size[0] = 2'd3; e_wr[0] = 1'b1;
    e_addr[1] = BASE + 15;         e_size[1] = 2'd1; e_wr[1] = 1'b1;
    e_addr[2] = BASE + 12;         e_size[2] = 2'd2; e_wr[2] = 1'b1;
    e_addr[3] = BASE + 4 * DEPTH;  e_size[3] = 2'd3; e_wr[3] = 1'b1;
    e_addr[4] = BASE + 1;          e_size[4] = 2'd3; e_wr[4] = 1'b0;
    e_addr[5] = BASE + 4 * DEPTH;  e_size[5] = 2'd3; e_wr[5] = 1'b0;
    e_addr[6] = BASE - 4;          e_size[6] = 2'd3; e_wr[6] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      txn(e_wr[i], e_addr[i], 32'hFFFFFFFF, e_size[i], 1'b0, rd, er);
      chk1($sformatf("err%0d_flag", i), er, 1'b1);
      chk($sformatf("err%0d_rdata", i), rd, 32'h0);
    end
    txn(1'b0, BASE + 0, 32'h0, 2'd3, 1'b0, rd, er);
    chk("unchanged_w0", rd, 32'hCAFEF00D);
    txn(1'b0, BASE + 4, 32'h0, 2'd3, 1'b0, rd, er);
    chk("unchanged_w1", rd, 32'hDEADBEEF);
    txn(1'b0, BASE + 12, 32'h0, 2'd3, 1'b0, rd, er);
    chk("unchanged_w3", rd, 32'h80013344);

    // Back-pressure with req_valid held: response stable, no second accept.
    start_req(1'b0, BASE + 4, 32'h0, 2'd3, 1'b0, 1'b1);
    bus.req_addr = BASE + 12;
    wait_resp(lat);
    chk("stall_latency", 32'(lat), 32'(LAT));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk1("stall_valid", bus.resp_valid, 1'b1);
      chk("stall_rdata", bus.resp_rdata, 32'hDEADBEEF);
      chk1("stall_ready", bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b0;
    hs();
    chk1("stall_hs_valid", bus.resp_valid, 1'b0);
    chk1("stall_hs_ready", bus.req_ready, 1'b1);
    repeat (6) @(posedge clk); #1;
    chk1("no_second_accept", bus.resp_valid, 1'b0);

    // resp_ready while idle has no effect.
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk1("idle_rr_valid", bus.resp_valid, 1'b0);
    chk1("idle_rr_ready", bus.req_ready, 1'b1);
    bus.resp_ready = 1'b0;

    // Reset during ACCESS discards the store.
    txn(1'b1, BASE + 16, 32'h0, 2'd3, 1'b0, rd, er);
    start_req(1'b1, BASE + 16, 32'h12345678, 2'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk1("acc_rst_ready", bus.req_ready, 1'b0);
    chk1("acc_rst_valid", bus.resp_valid, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk1("acc_rel_ready0", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("acc_rel_ready1", bus.req_ready, 1'b1);
    txn(1'b0, BASE + 16, 32'h0, 2'd3, 1'b0, rd, er);
    chk("acc_rst_discard", rd, 32'h0);

    // Reset during RESPOND keeps the committed store.
    start_req(1'b1, BASE + 20, 32'h55AA55AA, 2'd3, 1'b0, 1'b0);
    wait_resp(lat);
    chk1("resp_rst_pre_valid", bus.resp_valid, 1'b1);
    rst_n = 1'b0;
    #1 chk1("resp_rst_drop", bus.resp_valid, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, BASE + 20, 32'h0, 2'd3, 1'b0, rd, er);
    chk("resp_rst_kept", rd, 32'h55AA55AA);
    txn(1'b0, BASE + 0, 32'h0, 2'd3, 1'b0, rd, er);
    chk("array_not_reset", rd, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
